// File: rtl/mux_n_skid_pkg.sv
// Shared defaults and encodings for the mux_n_skid family.
// Holds default geometry, forwarding-select encodings and the skid state type.
package mux_n_skid_pkg;

    localparam int unsigned MUX_WIDTH_DEF = 32;
    localparam int unsigned MUX_N_DEF     = 5;
    localparam int unsigned MUX_SELW_DEF  = 3;

    typedef enum logic [2:0] {
        FWD_RF  = 3'd0,
        FWD_EX  = 3'd1,
        FWD_MEM = 3'd2,
        FWD_WB  = 3'd3,
        FWD_IMM = 3'd4
    } fwd_sel_e;

    // Encoded as {skid_valid, out_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 mux; any select >= N falls back to channel N-1.
module mux_n import mux_n_skid_pkg::*; #(
    parameter int unsigned WIDTH = MUX_WIDTH_DEF,
    parameter int unsigned N     = MUX_N_DEF,
    parameter int unsigned SEL_W = MUX_SELW_DEF
) (
    input  logic [N*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]   Op,
    output logic [WIDTH-1:0]   Out
);

    always_comb begin
        Out = In[(N-1)*WIDTH +: WIDTH];
        for (int unsigned k = 0; k < N; k++) begin
            if (Op == SEL_W'(k)) Out = In[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_n_skid.sv
// N-input select mux with registered valid/ready output and a 2-entry skid buffer.
// Optional sticky out-of-range select flag enabled by defining MUX_SEL_ERR_EN.
module mux_n_skid import mux_n_skid_pkg::*; #(
    parameter int unsigned WIDTH = MUX_WIDTH_DEF,
    parameter int unsigned N     = MUX_N_DEF,
    parameter int unsigned SEL_W = MUX_SELW_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] In,
    input  logic [SEL_W-1:0]   Op,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   Out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             accept;
    logic             consume;
    skid_state_e      state;

    mux_n #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) u_mux (
        .In  (In),
        .Op  (Op),
        .Out (sel_data)
    );

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;
    assign state   = skid_state_e'({skid_valid, out_valid});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Out        <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (flush) begin
            // Data registers keep their contents; only the valids drop.
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        Out       <= sel_data;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        Out <= sel_data;
                    end else if (accept) begin
                        skid_data  <= sel_data;
                        skid_valid <= 1'b1;
                        in_ready   <= 1'b0;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (consume) begin
                        Out        <= skid_data;
                        skid_valid <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end
                default: begin
                    out_valid  <= 1'b0;
                    skid_valid <= 1'b0;
                    in_ready   <= 1'b1;
                end
            endcase
        end
    end

`ifdef MUX_SEL_ERR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (flush) begin
            sel_err <= 1'b0;
        end else if (accept && (32'(Op) >= N)) begin
            sel_err <= 1'b1;
        end
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_skid.sv
// Self-checking bench for mux_n_skid: directed scenarios on a 5x32 instance,
// randomized handshake traffic on a 3x8 instance against a queue model.
module tb_mux_n_skid;

`ifdef MUX_SEL_ERR_EN
    localparam bit SEL_ERR_EN = 1'b1;
`else
    localparam bit SEL_ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;

    logic [159:0] in5;
    logic [2:0]   op5;
    logic         iv5, ir5, fl5, ov5, ordy5, se5;
    logic [31:0]  out5;

    logic [23:0]  in3;
    logic [1:0]   op3;
    logic         iv3, ir3, fl3, ov3, ordy3, se3;
    logic [7:0]   out3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_n_skid #(.WIDTH(32), .N(5), .SEL_W(3)) dut5 (
        .clk(clk), .reset_n(reset_n), .In(in5), .Op(op5), .in_valid(iv5),
        .in_ready(ir5), .flush(fl5), .Out(out5), .out_valid(ov5),
        .out_ready(ordy5), .sel_err(se5)
    );

    mux_n_skid #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .In(in3), .Op(op3), .in_valid(iv3),
        .in_ready(ir3), .flush(fl3), .Out(out3), .out_valid(ov3),
        .out_ready(ordy3), .sel_err(se3)
    );

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in5 = '0; op5 = '0; iv5 = 1'b0; fl5 = 1'b0; ordy5 = 1'b0;
        in3 = '0; op3 = '0; iv3 = 1'b0; fl3 = 1'b0; ordy3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", ov5); end
        checks++; if (out5 !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", out5); end
        checks++; if (ir5 !== 1'b1) begin errors++; $display("FAIL reset_ir: got %b expected 1", ir5); end
        checks++; if (se5 !== 1'b0) begin errors++; $display("FAIL reset_se: got %b expected 0", se5); end
        checks++; if (ov3 !== 1'b0 || ir3 !== 1'b1) begin errors++; $display("FAIL reset_dut3: got ov=%b ir=%b expected ov=0 ir=1", ov3, ir3); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_stream();
        ordy5 = 1'b1;
        for (int k = 0; k < 5; k++) in5[k*32 +: 32] = 32'hA0 + k;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            op5 = 3'(k); iv5 = 1'b1;
            @(posedge clk); #1;
            checks++; if (ov5 !== 1'b1) begin errors++; $display("FAIL stream_ov[%0d]: got %b expected 1", k, ov5); end
            checks++; if (out5 !== 32'hA0 + k) begin errors++; $display("FAIL stream_out[%0d]: got %h expected %h", k, out5, 32'hA0 + k); end
            checks++; if (ir5 !== 1'b1) begin errors++; $display("FAIL stream_ir[%0d]: got %b expected 1", k, ir5); end
            checks++; if (se5 !== 1'b0) begin errors++; $display("FAIL stream_se[%0d]: got %b expected 0", k, se5); end
        end
        @(negedge clk);
        iv5 = 1'b0;
        @(posedge clk); #1;
        checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", ov5); end
    endtask

    task automatic test_sel_err();
        @(negedge clk);
        in5[4*32 +: 32] = 32'hDEAD; op5 = 3'd6; iv5 = 1'b1; ordy5 = 1'b1;
        @(posedge clk); #1;
        checks++; if (out5 !== 32'hDEAD || ov5 !== 1'b1) begin errors++; $display("FAIL oob_out: got %h/%b expected dead/1", out5, ov5); end
        checks++; if (se5 !== SEL_ERR_EN) begin errors++; $display("FAIL oob_se: got %b expected %b", se5, SEL_ERR_EN); end
        @(negedge clk);
        iv5 = 1'b0;
        @(posedge clk); #1;
        checks++; if (se5 !== SEL_ERR_EN) begin errors++; $display("FAIL oob_sticky: got %b expected %b", se5, SEL_ERR_EN); end
        @(negedge clk);
        fl5 = 1'b1;
        @(posedge clk); #1;
        checks++; if (se5 !== 1'b0) begin errors++; $display("FAIL oob_flush_clear: got %b expected 0", se5); end
        @(negedge clk);
        fl5 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] items [3];
        items[0] = 32'h11; items[1] = 32'h22; items[2] = 32'h33;
        ordy5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op5 = 3'($urandom_range(0, 4));
            in5[int'(op5)*32 +: 32] = items[i];
            iv5 = 1'b1;
            @(posedge clk); #1;
            checks++; if (out5 !== 32'h11 || ov5 !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got %h/%b expected 11/1", i, out5, ov5); end
            checks++; if (ir5 !== (i == 0)) begin errors++; $display("FAIL bp_ir[%0d]: got %b expected %b", i, ir5, (i == 0)); end
        end
        @(negedge clk);
        ordy5 = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (out5 !== items[i] || ov5 !== 1'b1) begin errors++; $display("FAIL bp_release[%0d]: got %h/%b expected %h/1", i, out5, ov5, items[i]); end
            checks++; if (ir5 !== 1'b1) begin errors++; $display("FAIL bp_release_ir[%0d]: got %b expected 1", i, ir5); end
            if (i == 2) begin
                @(negedge clk);
                iv5 = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", ov5); end
    endtask

    task automatic test_flush();
        logic [31:0] a;
        a = $urandom;
        @(negedge clk);
        ordy5 = 1'b0; op5 = 3'd7; in5[4*32 +: 32] = a; iv5 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op5 = 3'd2; in5[2*32 +: 32] = $urandom;
        @(posedge clk); #1;
        checks++; if (ir5 !== 1'b0 || ov5 !== 1'b1) begin errors++; $display("FAIL flush_full: got ir=%b ov=%b expected ir=0 ov=1", ir5, ov5); end
        checks++; if (se5 !== SEL_ERR_EN) begin errors++; $display("FAIL flush_pre_se: got %b expected %b", se5, SEL_ERR_EN); end
        @(negedge clk);
        fl5 = 1'b1; ordy5 = 1'b1; op5 = 3'd0; in5[31:0] = $urandom;
        @(posedge clk); #1;
        checks++; if (ov5 !== 1'b0 || ir5 !== 1'b1) begin errors++; $display("FAIL flush_state: got ov=%b ir=%b expected ov=0 ir=1", ov5, ir5); end
        checks++; if (se5 !== 1'b0) begin errors++; $display("FAIL flush_se: got %b expected 0", se5); end
        checks++; if (out5 !== a) begin errors++; $display("FAIL flush_out_kept: got %h expected %h", out5, a); end
        @(negedge clk);
        fl5 = 1'b0; iv5 = 1'b0;
        @(posedge clk); #1;
        checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got %b expected 0", ov5); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        @(negedge clk);
        ordy5 = 1'b1; op5 = 3'd1; in5[32 +: 32] = 32'h5A5A_0001; iv5 = 1'b1;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        checks++; if (ov5 !== 1'b0 || out5 !== 32'h0 || ir5 !== 1'b1) begin errors++; $display("FAIL async_reset: got ov=%b out=%h ir=%b expected 0/0/1", ov5, out5, ir5); end
        iv5 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        d = $urandom; op5 = 3'd3; in5[3*32 +: 32] = d; iv5 = 1'b1;
        @(posedge clk); #1;
        checks++; if (ov5 !== 1'b1 || out5 !== d) begin errors++; $display("FAIL post_reset_latency: got %h/%b expected %h/1", out5, ov5, d); end
        @(negedge clk);
        iv5 = 1'b0;
        @(posedge clk); #1;
        checks++; if (ov5 !== 1'b0) begin errors++; $display("FAIL post_reset_drain: got %b expected 0", ov5); end
    endtask

    task automatic test_random();
        logic [7:0] ch [3];
        logic [7:0] q [$];
        logic [7:0] held, exp;
        bit         acc, con, stalled, pending;
        int         idx;
        held = '0; stalled = 0; pending = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            checks++; if (ov3 !== (q.size() > 0)) begin errors++; $display("FAIL rnd_ov c=%0d: got %b expected %b", c, ov3, (q.size() > 0)); end
            checks++; if (ir3 !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ir c=%0d: got %b expected %b", c, ir3, (q.size() < 2)); end
            if (q.size() > 0) begin
                checks++; if (out3 !== q[0]) begin errors++; $display("FAIL rnd_out c=%0d: got %h expected %h", c, out3, q[0]); end
            end
            if (stalled) begin
                checks++; if (out3 !== held) begin errors++; $display("FAIL rnd_stable c=%0d: got %h expected %h", c, out3, held); end
            end
            if (!pending) begin
                for (int k = 0; k < 3; k++) ch[k] = 8'($urandom);
                op3 = 2'($urandom_range(0, 3));
                iv3 = 1'($urandom_range(0, 1));
                in3 = {ch[2], ch[1], ch[0]};
            end
            ordy3 = 1'($urandom_range(0, 1));
            idx = (int'(op3) < 3) ? int'(op3) : 2;
            exp = ch[idx];
            acc = iv3 && (q.size() < 2);
            con = (q.size() > 0) && ordy3;
            stalled = (q.size() > 0) && !ordy3;
            if (q.size() > 0) held = q[0];
            pending = iv3 && !acc;
            @(posedge clk); #1;
            if (con) void'(q.pop_front());
            if (acc) q.push_back(exp);
        end
        @(negedge clk);
        iv3 = 1'b0; ordy3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_sel_err();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
